multi_port_adapter: RTL and testbench

- Parametrised successor to the single-block interface adapter on the 6502 bus.
- Provides NUM_PORTS 8-bit GPIO ports, each with its own data-direction register, plus a reloadable down-counter timer.
- Has an interrupt flag/enable pair and drives an active-low IRQ line toward the CPU.
- Sits behind the address decoder; chip_en is asserted for its 16-byte window, and the low address nibble selects the register.

---
 rtl/multi_port_adapter_pkg.sv | 25 ++
 rtl/multi_port_adapter_if.sv | 22 ++
 rtl/multi_port_adapter_timer.sv | 72 +++++++
 rtl/multi_port_adapter.sv | 141 ++++++++++++++
 tb/tb_multi_port_adapter.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_port_adapter_pkg.sv
// Shared register map, bit indices and read helper for the multi-port 6502 adapter.
// Optional edge interrupts are enabled with the PORT_EDGE_IRQ_EN macro (see top level).
package multi_port_adapter_pkg;

    localparam logic [3:0] REG_T_LO = 4'h8;
    localparam logic [3:0] REG_T_HI = 4'h9;
    localparam logic [3:0] REG_CTRL = 4'hA;
    localparam logic [3:0] REG_IFR  = 4'hB;
    localparam logic [3:0] REG_IER  = 4'hC;

    localparam int unsigned CTRL_CONT = 0;
    localparam int unsigned CTRL_RUN  = 1;

    localparam int unsigned IFR_TIMER     = 0;
    localparam int unsigned IFR_EDGE_BASE = 1;
    localparam int unsigned IFR_WIDTH     = 5;

    // Output bits come from the output register, input bits from the pins.
    function automatic logic [7:0] port_read(input logic [7:0] out_v,
                                             input logic [7:0] dir_v,
                                             input logic [7:0] pin_v);
        return (out_v & dir_v) | (pin_v & ~dir_v);
    endfunction

endpackage

// File: rtl/multi_port_adapter_if.sv
// CPU-side register bus of the multi-port adapter: select, strobes, data and IRQ line.
// Build option PORT_EDGE_IRQ_EN does not change this interface.
interface multi_port_adapter_if;

    logic       chip_en;
    logic       wrt_en;
    logic [3:0] register_select;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       irq_n;

    modport master (
        output chip_en, wrt_en, register_select, data_in,
        input  data_out, irq_n
    );

    modport slave (
        input  chip_en, wrt_en, register_select, data_in,
        output data_out, irq_n
    );

endinterface

// File: rtl/multi_port_adapter_timer.sv
// Reloadable down-counter: LATCH, COUNT, RUN/CONT control and the expiry pulse.
// Unaffected by the PORT_EDGE_IRQ_EN build option.
module adapter_timer
    import multi_port_adapter_pkg::*;
#(
    parameter int unsigned TIMER_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we_lo,
    input  logic                   we_hi,
    input  logic                   we_ctrl,
    input  logic [7:0]             wdata,
    output logic [TIMER_WIDTH-1:0] count,
    output logic                   run,
    output logic                   cont,
    output logic                   expire
);

    logic [TIMER_WIDTH-1:0] latch_q, latch_d;
    logic [TIMER_WIDTH-1:0] count_q, count_d;
    logic                   run_q, run_d;
    logic                   cont_q, cont_d;

    // Expiry depends only on current state, so a same-edge write never hides it.
    assign expire = run_q && (count_q == '0);

    always_comb begin
        latch_d = latch_q;
        count_d = count_q;
        run_d   = run_q;
        cont_d  = cont_q;
        if (run_q) begin
            if (!expire)
                count_d = count_q - TIMER_WIDTH'(1);
            else if (cont_q)
                count_d = latch_q;
            else
                run_d = 1'b0;
        end
        if (we_ctrl) begin
            cont_d = wdata[CTRL_CONT];
            run_d  = wdata[CTRL_RUN];
        end
        if (we_lo)
            latch_d[7:0] = wdata;
        if (we_hi) begin
            latch_d[TIMER_WIDTH-1:8] = wdata[TIMER_WIDTH-9:0];
            count_d = latch_d;
            run_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            latch_q <= '1;
            count_q <= '1;
            run_q   <= 1'b0;
            cont_q  <= 1'b0;
        end else begin
            latch_q <= latch_d;
            count_q <= count_d;
            run_q   <= run_d;
            cont_q  <= cont_d;
        end
    end

    assign count = count_q;
    assign run   = run_q;
    assign cont  = cont_q;

endmodule

// File: rtl/multi_port_adapter.sv
// NUM_PORTS GPIO ports with DDRs, a down-counter timer and IFR/IER-driven active-low IRQ.
// Define PORT_EDGE_IRQ_EN to add synchronised falling-edge interrupts on each port's pin 0.
module multi_port_adapter
    import multi_port_adapter_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned TIMER_WIDTH = 16,
    parameter logic [7:0]  RESET_DDR   = 8'h00
) (
    input  logic                   clk,
    input  logic                   reset,
    multi_port_adapter_if.slave    bus,
    input  logic [8*NUM_PORTS-1:0] port_in,
    output logic [8*NUM_PORTS-1:0] port_out,
    output logic [8*NUM_PORTS-1:0] port_dir
);

    localparam int unsigned PW = 8 * NUM_PORTS;
`ifdef PORT_EDGE_IRQ_EN
    localparam logic [IFR_WIDTH-1:0] IRQ_MASK = 5'b11111;
`else
    localparam logic [IFR_WIDTH-1:0] IRQ_MASK = 5'b00001;
`endif

    logic                   wr;
    logic [PW-1:0]          out_q, out_d, ddr_q, ddr_d;
    logic [IFR_WIDTH-1:0]   ifr_q, ifr_d, ier_q, ier_d;
    logic [IFR_WIDTH-1:0]   ifr_set, ifr_clr, edge_set;
    logic                   irq_n_q, irq_n_d;
    logic [TIMER_WIDTH-1:0] count;
    logic                   run, cont, expire;
    logic [7:0]             rdata;

    assign wr = bus.chip_en && bus.wrt_en;

    adapter_timer #(.TIMER_WIDTH(TIMER_WIDTH)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .we_lo   (wr && (bus.register_select == REG_T_LO)),
        .we_hi   (wr && (bus.register_select == REG_T_HI)),
        .we_ctrl (wr && (bus.register_select == REG_CTRL)),
        .wdata   (bus.data_in),
        .count   (count),
        .run     (run),
        .cont    (cont),
        .expire  (expire)
    );

`ifdef PORT_EDGE_IRQ_EN
    logic [NUM_PORTS-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;

    always_comb begin
        sync1_d  = '0;
        edge_set = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            sync1_d[p] = port_in[8*p];
            edge_set[IFR_EDGE_BASE+p] = prev_q[p] & ~sync2_q[p];
        end
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end
`else
    assign edge_set = '0;
`endif

    always_comb begin
        out_d   = out_q;
        ddr_d   = ddr_q;
        ier_d   = ier_q;
        ifr_clr = '0;
        if (wr) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (bus.register_select == 4'(2*p))
                    out_d[8*p +: 8] = bus.data_in;
                if (bus.register_select == 4'(2*p+1))
                    ddr_d[8*p +: 8] = bus.data_in;
            end
            if (bus.register_select == REG_IFR)
                ifr_clr = bus.data_in[IFR_WIDTH-1:0];
            if (bus.register_select == REG_IER)
                ier_d = bus.data_in[IFR_WIDTH-1:0] & IRQ_MASK;
        end
        ifr_set = edge_set;
        ifr_set[IFR_TIMER] = expire;
        // Sets are OR-ed in after the clear so a same-edge event survives.
        ifr_d   = ((ifr_q & ~ifr_clr) | ifr_set) & IRQ_MASK;
        irq_n_d = ~|(ifr_d & ier_d);
    end

    always_comb begin
        rdata = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (bus.register_select == 4'(2*p))
                rdata = port_read(out_q[8*p +: 8], ddr_q[8*p +: 8], port_in[8*p +: 8]);
            if (bus.register_select == 4'(2*p+1))
                rdata = ddr_q[8*p +: 8];
        end
        case (bus.register_select)
            REG_T_LO: rdata = count[7:0];
            REG_T_HI: rdata = 8'(count[TIMER_WIDTH-1:8]);
            REG_CTRL: rdata = {6'b0, run, cont};
            REG_IFR:  rdata = {3'b0, ifr_q};
            REG_IER:  rdata = {3'b0, ier_q};
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q   <= '0;
            ddr_q   <= {NUM_PORTS{RESET_DDR}};
            ifr_q   <= '0;
            ier_q   <= '0;
            irq_n_q <= 1'b1;
        end else begin
            out_q   <= out_d;
            ddr_q   <= ddr_d;
            ifr_q   <= ifr_d;
            ier_q   <= ier_d;
            irq_n_q <= irq_n_d;
        end
    end

    assign bus.data_out = rdata;
    assign bus.irq_n    = irq_n_q;
    assign port_out     = out_q;
    assign port_dir     = ddr_q;

endmodule

// File: tb/tb_multi_port_adapter.sv
// Scoreboard bench for multi_port_adapter: timeline-based reference model, queue-fed monitor.
// Works with or without PORT_EDGE_IRQ_EN defined.
module tb_multi_port_adapter;
    import multi_port_adapter_pkg::*;

    localparam int NP = 2;
    localparam logic [7:0] RDDR = 8'h00;
`ifdef PORT_EDGE_IRQ_EN
    localparam logic [4:0] IER_MASK = 5'h1F;
`else
    localparam logic [4:0] IER_MASK = 5'h01;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [8*NP-1:0] port_in = '0;
    logic [8*NP-1:0] port_out, port_dir;

    multi_port_adapter_if bus();

    multi_port_adapter #(.NUM_PORTS(NP), .TIMER_WIDTH(16), .RESET_DDR(RDDR)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .port_in  (port_in),
        .port_out (port_out),
        .port_dir (port_dir)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  data;
        logic        irq;
        logic [15:0] pout;
        logic [15:0] pdir;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Edge counter and per-edge samples of every port's pin 0 (index = edge number).
    longint cyc = 0;
    logic [3:0] hist[$];
    initial hist.push_back(4'h0);

    always @(posedge clk) begin : sampler
        logic [3:0] s;
        s = '0;
        for (int p = 0; p < NP; p++) s[p] = port_in[8*p];
        cyc = cyc + 1;
        hist.push_back(s);
    end

    // Timer modelled as segments: state snapshot at edge s_edge, evolution computed arithmetically.
    logic [7:0]  m_out[NP];
    logic [7:0]  m_ddr[NP];
    logic [15:0] m_latch;
    logic [4:0]  m_ier;
    longint      s_edge, reset_edge, closed_exp;
    logic [15:0] s_count;
    logic        s_run, s_cont;
    longint      clr_edge[5];

    function automatic void t_eval(input longint n, output logic [15:0] c,
                                   output logic r, output longint le);
        longint e, first, k, per;
        e = n - s_edge;
        c = s_count;
        r = s_run;
        le = -1;
        if (!s_run || e == 0) return;
        first = longint'(s_count) + 1;
        if (e < first) begin
            c = s_count - 16'(e);
            return;
        end
        if (!s_cont) begin
            c = '0;
            r = 1'b0;
            le = s_edge + first;
            return;
        end
        per = longint'(m_latch) + 1;
        k = e - first;
        c = m_latch - 16'(k % per);
        le = s_edge + first + (k / per) * per;
    endfunction

    task automatic reseg(input longint w);
        logic [15:0] c;
        logic r;
        longint le;
        t_eval(w, c, r, le);
        if (le > closed_exp) closed_exp = le;
        s_edge = w;
        s_count = c;
        s_run = r;
    endtask

    function automatic logic h(input longint k, input int p);
        if (k <= reset_edge || k < 0 || k >= longint'(hist.size())) return 1'b0;
        return hist[k][p];
    endfunction

    function automatic logic [4:0] m_ifr(input longint n);
        logic [15:0] c;
        logic r;
        longint le, last;
        logic [4:0] f;
        f = '0;
        t_eval(n, c, r, le);
        last = (le > closed_exp) ? le : closed_exp;
        f[0] = (last >= 0) && (last >= clr_edge[0]);
`ifdef PORT_EDGE_IRQ_EN
        for (int p = 0; p < NP; p++)
            for (longint m = n; m >= clr_edge[1+p] && m > reset_edge; m--)
                if (h(m-3, p) && !h(m-2, p)) f[1+p] = 1'b1;
`endif
        return f;
    endfunction

    function automatic logic [7:0] m_read(input logic [3:0] a, input longint n);
        logic [15:0] c;
        logic r;
        longint le;
        int p;
        t_eval(n, c, r, le);
        p = int'(a) / 2;
        if (int'(a) < 2*NP)
            return a[0] ? m_ddr[p]
                        : ((m_out[p] & m_ddr[p]) | (port_in[8*p +: 8] & ~m_ddr[p]));
        case (a)
            4'h8: return c[7:0];
            4'h9: return c[15:8];
            4'hA: return {6'b0, r, s_cont};
            4'hB: return {3'b0, m_ifr(n)};
            4'hC: return {3'b0, m_ier};
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [15:0] m_vec(input bit dir);
        logic [15:0] v;
        v = '0;
        for (int p = 0; p < NP; p++) v[8*p +: 8] = dir ? m_ddr[p] : m_out[p];
        return v;
    endfunction

    task automatic m_write(input logic [3:0] a, input logic [7:0] d, input longint w);
        if (int'(a) < 2*NP) begin
            if (a[0]) m_ddr[int'(a)/2] = d;
            else      m_out[int'(a)/2] = d;
        end
        case (a)
            4'h8: begin reseg(w); m_latch[7:0] = d; end
            4'h9: begin reseg(w); m_latch[15:8] = d; s_count = m_latch; s_run = 1'b1; end
            4'hA: begin reseg(w); s_cont = d[0]; s_run = d[1]; end
            4'hB: for (int b = 0; b < 5; b++) if (d[b]) clr_edge[b] = w;
            4'hC: m_ier = d[4:0] & IER_MASK;
            default: ;
        endcase
    endtask

    task automatic m_reset(input longint r);
        for (int p = 0; p < NP; p++) begin
            m_out[p] = 8'h00;
            m_ddr[p] = RDDR;
        end
        m_latch = '1;
        m_ier = '0;
        s_edge = r;
        s_count = '1;
        s_run = 1'b0;
        s_cont = 1'b0;
        closed_exp = -1;
        reset_edge = r;
        for (int b = 0; b < 5; b++) clr_edge[b] = r;
    endtask

    task automatic push_exp(input logic [3:0] a, input string nm);
        exp_t e;
        e.name = nm;
        e.data = m_read(a, cyc);
        e.irq  = ~|(m_ifr(cyc) & m_ier);
        e.pout = m_vec(1'b0);
        e.pdir = m_vec(1'b1);
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.chip_en = 1'b1;
        bus.wrt_en = 1'b1;
        bus.register_select = a;
        bus.data_in = d;
        m_write(a, d, cyc + 1);
        @(posedge clk); #1;
        bus.chip_en = 1'b0;
        bus.wrt_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input string nm);
        bus.chip_en = 1'b1;
        bus.wrt_en = 1'b0;
        bus.register_select = a;
        push_exp(a, nm);
        @(posedge clk); #1;
        bus.chip_en = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.chip_en && !bus.wrt_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_read: got addr %h, expected no read", bus.register_select);
            end else begin
                e = exp_q.pop_front();
                chk({e.name, "_data"}, 16'(bus.data_out), 16'(e.data));
                chk({e.name, "_irq_n"}, 16'(bus.irq_n), 16'(e.irq));
                chk({e.name, "_port_out"}, port_out, e.pout);
                chk({e.name, "_port_dir"}, port_dir, e.pdir);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1);
    end

    initial begin : stim
        logic [3:0] a;
        logic [7:0] d;
        bus.chip_en = 1'b0;
        bus.wrt_en = 1'b0;
        bus.register_select = '0;
        bus.data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        m_reset(cyc);

        for (int i = 0; i < 16; i++) rd(4'(i), "reset_reg");

        port_in = 16'h003C;
        wr(4'h1, 8'hF0);
        wr(4'h0, 8'hA5);
        rd(4'h0, "port0_mix");
        rd(4'h1, "ddr0");

        wr(REG_IER, 8'h01);
        wr(REG_T_LO, 8'h03);
        wr(REG_CTRL, 8'h00);
        wr(REG_T_HI, 8'h00);
        for (int i = 0; i < 6; i++) rd(REG_IFR, "oneshot_ifr");
        rd(REG_CTRL, "oneshot_ctrl");
        rd(REG_T_LO, "oneshot_count");

        wr(REG_T_LO, 8'h02);
        wr(REG_CTRL, 8'h03);
        wr(REG_T_HI, 8'h00);
        for (int i = 0; i < 6; i++) begin
            wr(REG_IFR, 8'h01);
            rd(REG_IFR, "cont_clear");
        end
        rd(REG_T_LO, "cont_count");

        wr(REG_T_LO, 8'h40);
        wr(REG_CTRL, 8'h00);
        wr(REG_T_HI, 8'h00);
        rd(REG_T_LO, "precut_count");
        reset = 1'b0;
        m_reset(cyc);
        bus.chip_en = 1'b1;
        bus.wrt_en = 1'b0;
        bus.register_select = REG_T_LO;
        push_exp(REG_T_LO, "midreset_count");
        @(negedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        bus.chip_en = 1'b0;
        rd(REG_T_HI, "midreset_thi");
        rd(REG_CTRL, "midreset_ctrl");

        wr(REG_IER, 8'h04);
        port_in = 16'h0100;
        repeat (4) rd(REG_IFR, "edge_pre");
        port_in = 16'h0000;
        repeat (5) rd(REG_IFR, "edge_post");

        for (int i = 0; i < 400; i++) begin
            a = 4'($urandom_range(0, 15));
            d = 8'($urandom);
            case ($urandom_range(0, 6))
                0, 1: begin
                    if (a == REG_T_HI && $urandom_range(0, 3) != 0) d = 8'h00;
                    if (a == REG_T_LO && $urandom_range(0, 1) != 0) d = d & 8'h07;
                    wr(a, d);
                end
                2, 3: rd(a, "rand_read");
                4: begin
                    port_in = 16'($urandom);
                    rd(4'($urandom_range(0, 2*NP-1)), "rand_pin");
                end
                5: wr(REG_IFR, d);
                default: wr(REG_CTRL, d & 8'h03);
            endcase
        end
        rd(REG_IFR, "final_ifr");

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
